// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational instruction ROM between the CPU
// fetch port (port 0) and the debug/boot reader (port 1). Per-cycle
// round-robin grant with a burst cap, registered read return (1-cycle latency).
// Optional feature macro: ROM_ARB_OOR_EN (out-of-range reads return a NOP and
// pulse oor_err).
module rom_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int ROM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              oor_err
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    // Parameter sanity checks at elaboration.
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("rom_port_arbiter: MAX_BURST must be in 1..15");
    end
    if (ROM_DEPTH < 1) begin : g_bad_depth
        $error("rom_port_arbiter: ROM_DEPTH must be at least 1");
    end

    port_t            last_port;
    port_t            owner;
    port_t            gnt_port;
    logic             any_gnt;
    logic [CNT_W-1:0] burst_cnt;
    logic [DATA_W-1:0] rd_word;

    // Grant selection: single requester always wins; under contention the
    // burst cap overrides round-robin. Reset suppresses all grants.
    always_comb begin
        gnt_port = PORT0;
        any_gnt  = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                any_gnt = 1'b1;
                if (burst_cnt == BURST_MAX)
                    gnt_port = (owner == PORT0) ? PORT1 : PORT0;
                else
                    gnt_port = (last_port == PORT0) ? PORT1 : PORT0;
            end else if (m0_req) begin
                any_gnt  = 1'b1;
                gnt_port = PORT0;
            end else if (m1_req) begin
                any_gnt  = 1'b1;
                gnt_port = PORT1;
            end
        end
    end

    assign m0_gnt   = any_gnt && (gnt_port == PORT0);
    assign m1_gnt   = any_gnt && (gnt_port == PORT1);
    assign rom_addr = m1_gnt ? m1_addr : m0_addr;

`ifdef ROM_ARB_OOR_EN
    logic oor;

    assign oor     = (32'(rom_addr) >= 32'(ROM_DEPTH));
    assign rd_word = oor ? DATA_W'(32'h0000_0013) : rom_data;

    // Out-of-range flag travels with the read data so it lines up with rvalid.
    always_ff @(posedge clk) begin
        if (rst)
            oor_err <= 1'b0;
        else
            oor_err <= any_gnt && oor;
    end
`else
    assign rd_word = rom_data;
    assign oor_err = 1'b0;
`endif

    // Arbitration history and burst counter; idle cycles clear the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_port <= PORT1;
            owner     <= PORT0;
            burst_cnt <= '0;
        end else if (any_gnt) begin
            last_port <= gnt_port;
            owner     <= gnt_port;
            if (gnt_port == owner)
                burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
            else
                burst_cnt <= CNT_W'(1);
        end else begin
            burst_cnt <= '0;
        end
    end

    // Read return: granted port captures ROM data one cycle later; the
    // other port's rdata holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (m0_gnt)
                m0_rdata <= rd_word;
            if (m1_gnt)
                m1_rdata <= rd_word;
        end
    end

endmodule
